// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor and its pipeline-side resolver.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } bp_state_e;

   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of 1-bit predictions; head is the oldest in-flight branch.
module pred_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     din_i,
   input  logic                     pop_i,
   output logic                     head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Issues prediction requests for fetched branches, queues the returned predictions
// and resolves them in order against execute-stage outcomes.
module branch_resolver
   import bp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     br_valid,
   output logic                     br_ready,
   input  logic                     resolve_valid,
   input  logic                     resolve_taken,
   input  logic                     flush,
   output logic                     request,
   input  logic                     prediction,
   output logic                     result,
   output logic                     taken,
   output logic                     pred_valid,
   output logic                     pred_taken,
   output logic                     mispredict,
   output logic [$clog2(DEPTH):0]   inflight,
   output logic [CNT_W-1:0]         branch_count,
   output logic [CNT_W-1:0]         mispred_count,
   output logic                     underflow_err
);

   localparam int IW = $clog2(DEPTH) + 1;

   logic             pending_q, pending_d;
   logic             result_q, result_d;
   logic             taken_q, taken_d;
   logic             mispredict_q, mispredict_d;
   logic             underflow_q, underflow_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic          fifo_head;
   logic [IW-1:0] fifo_count;
   logic          accept, capture, pop, has_entry, mismatch;

   // A reserved-but-uncaptured slot counts as occupied; ready depends on state only.
   assign inflight  = fifo_count + IW'(pending_q);
   assign br_ready  = (inflight < IW'(DEPTH));
   assign has_entry = (fifo_count != '0);
   assign accept    = br_valid & br_ready & ~flush & ~rst;
   assign capture   = pending_q & ~flush & ~rst;
   assign pop       = resolve_valid & has_entry & ~flush & ~rst;
   assign mismatch  = fifo_head ^ resolve_taken;

   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (flush),
      .push_i  (capture),
      .din_i   (prediction),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   always_comb begin
      pending_d     = accept;
      result_d      = pop;
      taken_d       = pop & resolve_taken;
      mispredict_d  = pop & mismatch;
      underflow_d   = underflow_q | (resolve_valid & ~has_entry & ~flush);
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (pop && (branch_cnt_q != '1)) begin
         branch_cnt_d = branch_cnt_q + 1'b1;
      end
      if (pop && mismatch && (mispred_cnt_q != '1)) begin
         mispred_cnt_d = mispred_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q     <= 1'b0;
         result_q      <= 1'b0;
         taken_q       <= 1'b0;
         mispredict_q  <= 1'b0;
         underflow_q   <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         pending_q     <= pending_d;
         result_q      <= result_d;
         taken_q       <= taken_d;
         mispredict_q  <= mispredict_d;
         underflow_q   <= underflow_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign request       = accept;
   assign pred_valid    = capture;
   assign pred_taken    = capture & prediction;
   assign result        = result_q;
   assign taken         = taken_q;
   assign mispredict    = mispredict_q;
   assign branch_count  = branch_cnt_q;
   assign mispred_count = mispred_cnt_q;
   assign underflow_err = underflow_q;

endmodule
